// File: rtl/icmp_pkg.sv
// Shared definitions for the ICMP echo filter and the downstream echo responder.
package icmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_DECIDE,
    S_SEND,
    S_DROP
  } state_t;

  localparam logic [7:0] IPV4_VER_IHL    = 8'h45;
  localparam logic [7:0] IP_PROTO_ICMP   = 8'h01;
  localparam logic [7:0] ICMP_ECHO_REQ   = 8'h08;
  localparam logic [7:0] ICMP_ECHO_REPLY = 8'h00;

  // Words 0-4 make up the 20-byte IPv4 header without options.
  localparam int unsigned HDR_WORDS     = 5;
  localparam int unsigned MIN_PKT_WORDS = 6;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/csum16_acc.sv
// 16-bit ones-complement accumulator with end-around carry; clear may coincide
// with add, in which case the sum restarts from the current operands.
module csum16_acc (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_add_en,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  logic [15:0] r_sum;
  logic [15:0] w_base;
  logic [17:0] w_s1;
  logic [16:0] w_s2;
  logic [15:0] w_fold;

  // Two folds: the first can leave a single carry (e.g. 0x1FFFF -> 0x10000).
  always_comb begin
    w_base = i_clear ? '0 : r_sum;
    w_s1   = {2'b00, w_base} + {2'b00, i_a} + {2'b00, i_b};
    w_s2   = {1'b0, w_s1[15:0]} + {15'd0, w_s1[17:16]};
    w_fold = w_s2[15:0] + {15'd0, w_s2[16]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= i_add_en ? w_fold : '0;
    end else if (i_add_en) begin
      r_sum <= w_fold;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/icmp_echo_filter.sv
// Store-and-forward filter passing only IPv4 ICMP echo requests downstream.
// Define ICMP_FILTER_CSUM_CHECK_EN to also require a valid IPv4 header checksum.
module icmp_echo_filter
  import icmp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] stream_in_data,
  input  logic [1:0]  stream_in_empty,
  input  logic        stream_in_valid,
  input  logic        stream_in_startofpacket,
  input  logic        stream_in_endofpacket,
  output logic        stream_in_ready,
  output logic [31:0] stream_out_data,
  output logic [1:0]  stream_out_empty,
  output logic        stream_out_valid,
  output logic        stream_out_startofpacket,
  output logic        stream_out_endofpacket,
  input  logic        stream_out_ready,
  output logic [15:0] pkt_pass_count,
  output logic [15:0] pkt_drop_count
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = $clog2(DEPTH_WORDS + 1);

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [CW-1:0]   r_wcnt;
  logic [CW-1:0]   r_txptr;
  logic [1:0]      r_empty;
  logic [7:0]      r_ver_ihl, r_proto, r_icmp_type;
  logic            r_in_ready;
  logic [31:0]     r_out_data;
  logic [1:0]      r_out_empty;
  logic            r_out_valid, r_out_sop, r_out_eop;
  logic [15:0]     r_pass_cnt, r_drop_cnt;

  logic            w_in_fire;
  logic            w_wr_en;
  logic [CW-1:0]   w_wr_idx;
  logic            w_drop_inc, w_pass_inc;
  logic            w_load_first, w_load_next;
  logic            w_match;
  logic            w_last_next;

  assign w_in_fire = stream_in_valid && r_in_ready;

`ifdef ICMP_FILTER_CSUM_CHECK_EN
  logic        w_csum_clr;
  logic        w_csum_add;
  logic [15:0] w_csum;

  assign w_csum_clr = (r_state == S_IDLE) && w_in_fire && stream_in_startofpacket;
  assign w_csum_add = w_wr_en && (w_wr_idx < CW'(HDR_WORDS));

  csum16_acc u_csum (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_csum_clr),
    .i_add_en (w_csum_add),
    .i_a      (stream_in_data[15:0]),
    .i_b      (stream_in_data[31:16]),
    .o_sum    (w_csum)
  );

  assign w_match = (r_wcnt >= CW'(MIN_PKT_WORDS)) && (r_ver_ihl == IPV4_VER_IHL) &&
                   (r_proto == IP_PROTO_ICMP) && (r_icmp_type == ICMP_ECHO_REQ) &&
                   (w_csum == 16'hFFFF);
`else
  assign w_match = (r_wcnt >= CW'(MIN_PKT_WORDS)) && (r_ver_ihl == IPV4_VER_IHL) &&
                   (r_proto == IP_PROTO_ICMP) && (r_icmp_type == ICMP_ECHO_REQ);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_wr_idx     = r_wcnt;
    w_drop_inc   = 1'b0;
    w_pass_inc   = 1'b0;
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_in_fire && stream_in_startofpacket) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = '0;
          w_state_nxt = stream_in_endofpacket ? S_DECIDE : S_RECV;
        end
      end
      S_RECV: begin
        if (w_in_fire) begin
          // A word beyond the buffer is not stored; an eop on it ends the packet here.
          if (r_wcnt == CW'(DEPTH_WORDS)) begin
            w_drop_inc  = stream_in_endofpacket;
            w_state_nxt = stream_in_endofpacket ? S_IDLE : S_DROP;
          end else begin
            w_wr_en = 1'b1;
            if (stream_in_endofpacket) w_state_nxt = S_DECIDE;
          end
        end
      end
      S_DECIDE: begin
        if (w_match) begin
          w_load_first = 1'b1;
          w_state_nxt  = S_SEND;
        end else begin
          w_drop_inc  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        if (r_out_valid && stream_out_ready) begin
          if (r_out_eop) begin
            w_pass_inc  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_load_next = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (w_in_fire && stream_in_endofpacket) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_last_next = (r_txptr == (r_wcnt - CW'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RECV) ||
                    (w_state_nxt == S_DROP);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx[AW-1:0]] <= stream_in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt      <= '0;
      r_empty     <= '0;
      r_ver_ihl   <= '0;
      r_proto     <= '0;
      r_icmp_type <= '0;
    end else if (w_wr_en) begin
      r_wcnt <= w_wr_idx + CW'(1);
      if (stream_in_endofpacket) r_empty <= stream_in_empty;
      if (w_wr_idx == CW'(0)) r_ver_ihl   <= stream_in_data[7:0];
      if (w_wr_idx == CW'(2)) r_proto     <= stream_in_data[15:8];
      if (w_wr_idx == CW'(5)) r_icmp_type <= stream_in_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_txptr     <= '0;
      r_out_data  <= '0;
      r_out_empty <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
    end else if (w_load_first) begin
      r_txptr     <= CW'(1);
      r_out_data  <= r_mem[0];
      r_out_valid <= 1'b1;
      r_out_sop   <= 1'b1;
      r_out_eop   <= (r_wcnt == CW'(1));
      r_out_empty <= (r_wcnt == CW'(1)) ? r_empty : 2'd0;
    end else if (w_load_next) begin
      r_txptr     <= r_txptr + CW'(1);
      r_out_data  <= r_mem[r_txptr[AW-1:0]];
      r_out_sop   <= 1'b0;
      r_out_eop   <= w_last_next;
      r_out_empty <= w_last_next ? r_empty : 2'd0;
    end else if (w_pass_inc) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pass_inc) r_pass_cnt <= sat_inc16(r_pass_cnt);
      if (w_drop_inc) r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign stream_in_ready          = r_in_ready;
  assign stream_out_data          = r_out_data;
  assign stream_out_empty         = r_out_empty;
  assign stream_out_valid         = r_out_valid;
  assign stream_out_startofpacket = r_out_sop;
  assign stream_out_endofpacket   = r_out_eop;
  assign pkt_pass_count           = r_pass_cnt;
  assign pkt_drop_count           = r_drop_cnt;

endmodule
